line_window_3x3: RTL

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

---
 rtl/median_pkg.sv | 17 +
 rtl/line_window_3x3_if.sv | 25 ++
 rtl/line_window_3x3_line_ram.sv | 21 ++
 rtl/line_window_3x3.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Definitions shared by the 3x3 window builder and the median stage:
// pixel width default, window geometry, window index mapping and FSM state type.
package median_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int WIN       = 3;
  localparam int WIN_N     = WIN * WIN;

  typedef enum logic {
    LW_IDLE   = 1'b0,
    LW_ACTIVE = 1'b1
  } lw_state_e;

  // Window slot k for line r (0 = oldest) and column c (0 = oldest).
  function automatic int win_idx(input int r, input int c);
    return WIN * r + c;
  endfunction
endpackage

// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out stream bundle of the 3x3 window builder.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the
// source holds data stable while valid && !ready and never waits on ready.
interface line_window_3x3_if #(
  parameter int PIX_W = median_pkg::PIX_W_DEF
);
  logic [PIX_W-1:0]                    in_pixel;
  logic                                in_sof;
  logic                                in_valid;
  logic                                in_ready;
  logic [median_pkg::WIN_N*PIX_W-1:0]  out_window;
  logic                                out_valid;
  logic                                out_eof;
  logic                                out_ready;

  modport master (
    output in_pixel, in_sof, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_eof
  );

  modport slave (
    input  in_pixel, in_sof, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_eof
  );
endinterface

// File: rtl/line_window_3x3_line_ram.sv
// Simple dual-port line memory: one write and one read per cycle at the same
// address; the read returns the contents from before this cycle's write.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/line_window_3x3.sv
// Raster pixel stream to 3x3 sliding windows (no border padding). Two line
// memories supply the older lines; the window shift register doubles as the output register.
module line_window_3x3
  import median_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       in_pixel,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIN_N*PIX_W-1:0] out_window,
  output logic                   out_valid,
  output logic                   out_eof,
  input  logic                   out_ready,
  output lw_state_e              dbg_state
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  lw_state_e        state_q, state_d;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic             acc, in_frame, emit, last_pix;
  logic             out_valid_q, out_eof_q;
  logic [PIX_W-1:0] ram0_rd, ram1_rd;
  logic [PIX_W-1:0] col_new [WIN];
  logic [PIX_W-1:0] win_q   [WIN][WIN];

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LW_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next state; counters hold the position of the next expected pixel
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (in_frame) begin
      if (last_pix) begin
        state_d = LW_IDLE;
        row_d   = '0;
        col_d   = '0;
      end else begin
        state_d = LW_ACTIVE;
        if (cur_col == CW'(IMG_WIDTH - 1)) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
          row_d = cur_row;
        end
      end
    end
  end

  // Outputs of the FSM; an accepted sof always restarts at (0,0)
  always_comb begin
    cur_row  = in_sof ? '0 : row_q;
    cur_col  = in_sof ? '0 : col_q;
    in_frame = acc && (in_sof || (state_q == LW_ACTIVE));
    emit     = in_frame && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last_pix = in_frame && (cur_row == RW'(IMG_HEIGHT - 1))
                        && (cur_col == CW'(IMG_WIDTH - 1));
  end

  // ram1 holds the previous line, ram0 the one before; lines cascade on each write
  line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(CW)) u_ram0 (
    .clk    (clk),
    .we_i   (in_frame),
    .addr_i (cur_col),
    .wdata_i(ram1_rd),
    .rdata_o(ram0_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(CW)) u_ram1 (
    .clk    (clk),
    .we_i   (in_frame),
    .addr_i (cur_col),
    .wdata_i(in_pixel),
    .rdata_o(ram1_rd)
  );

  always_comb begin
    col_new[0] = ram0_rd;
    col_new[1] = ram1_rd;
    col_new[2] = in_pixel;
  end

  // Shifts only on accepted frame pixels, which cannot happen while a window is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) win_q[r][c] <= '0;
    end else if (in_frame) begin
      for (int r = 0; r < WIN; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_eof_q   <= last_pix;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        out_window[PIX_W*win_idx(r, c) +: PIX_W] = win_q[r][c];
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign dbg_state = state_q;
endmodule
